// File: rtl/ram_responder_if.sv
// Bus between a requester and ram_responder: one request in flight, with
// completion signalled through the ramstate code.
interface ram_responder_if;
   // Handshake: the master raises exactly one of ramREN/ramWEN with a stable
   // word-aligned ramaddr (and ramstore for writes) and holds it until
   // ramstate reads ACCESS. The request completes on the rising edge that
   // ends the ACCESS cycle. ramload is valid only during ACCESS of a read.
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output ramaddr, ramstore, ramREN, ramWEN,
      input  ramload, ramstate
   );

   modport slave (
      input  ramaddr, ramstore, ramREN, ramWEN,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// Single-port word RAM that answers each request after LAT busy cycles,
// with abort, restart-on-change and error reporting for malformed requests.
module ram_responder #(
   parameter int LAT   = 2,
   parameter int WORDS = 1024
) (
   input  logic            CLK,
   input  logic            nRST,
   ram_responder_if.slave  bus,
   output logic [1:0]      fsm_state
);

   localparam int AW = $clog2(WORDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
   localparam logic [1:0] START_ST = (LAT == 0) ? ACC : WAIT;

   logic [1:0]    state, state_d;
   logic [3:0]    cnt, cnt_d;
   logic [AW-1:0] lat_idx, idx_d;
   logic          lat_we, we_d;
   logic [1:0]    ramstate_q, ramstate_d;
   logic [31:0]   mem [WORDS];

   logic          req_any, req_ok, in_range, wr_fire;
   logic [AW-1:0] req_idx;

   assign req_any  = bus.ramREN | bus.ramWEN;
   assign in_range = (bus.ramaddr >> (AW + 2)) == 32'd0;
   assign req_ok   = (bus.ramREN ^ bus.ramWEN) && (bus.ramaddr[1:0] == 2'b00) && in_range;
   assign req_idx  = bus.ramaddr[AW+1:2];

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = lat_idx;
      we_d    = lat_we;
      case (state)
         WAIT: begin
            if (!req_any) begin
               state_d = IDLE;
            end else if (!req_ok) begin
               state_d = ERR;
            end else if (req_idx != lat_idx || bus.ramWEN != lat_we) begin
               // request changed under us: restart the latency count
               idx_d = req_idx;
               we_d  = bus.ramWEN;
               cnt_d = CNT_INIT;
            end else if (cnt == 4'd0) begin
               state_d = ACC;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         default: begin
            // IDLE, ACC exit and ERR all accept a fresh request the same way
            if (req_ok) begin
               idx_d   = req_idx;
               we_d    = bus.ramWEN;
               cnt_d   = CNT_INIT;
               state_d = START_ST;
            end else if (req_any) begin
               state_d = ERR;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      ramstate_d = FREE;
      case (state_d)
         IDLE:    ramstate_d = FREE;
         WAIT:    ramstate_d = BUSY;
         ACC:     ramstate_d = ACCESS;
         default: ramstate_d = ERROR;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_idx    <= '0;
         lat_we     <= 1'b0;
         ramstate_q <= FREE;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         lat_idx    <= idx_d;
         lat_we     <= we_d;
         ramstate_q <= ramstate_d;
      end
   end

   // write data is sampled live on the edge leaving ACC
   assign wr_fire = (state == ACC) && lat_we && bus.ramWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      end else if (wr_fire) begin
         mem[lat_idx] <= bus.ramstore;
      end
   end

   assign bus.ramload  = (state == ACC && !lat_we) ? mem[lat_idx] : 32'd0;
   assign bus.ramstate = ramstate_q;
   assign fsm_state    = state;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances (LAT=2, 0, 3) share one
// stimulus bus; each scenario observes the instance selected by sel.
module tb_ram_responder;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] store = '0;
   logic        ren = 1'b0;
   logic        wen = 1'b0;
   int          sel = 2;
   int          total = 0;
   int          bad = 0;
   logic [31:0] rd;

   logic [1:0]  dbg2, dbg0, dbg3;
   logic [1:0]  obs_state;
   logic [31:0] obs_load;

   ram_responder_if if2 ();
   ram_responder_if if0 ();
   ram_responder_if if3 ();

   assign if2.ramaddr = addr;  assign if2.ramstore = store;
   assign if2.ramREN  = ren;   assign if2.ramWEN   = wen;
   assign if0.ramaddr = addr;  assign if0.ramstore = store;
   assign if0.ramREN  = ren;   assign if0.ramWEN   = wen;
   assign if3.ramaddr = addr;  assign if3.ramstore = store;
   assign if3.ramREN  = ren;   assign if3.ramWEN   = wen;

   ram_responder #(.LAT(2), .WORDS(1024)) dut2 (.CLK(clk), .nRST(nrst), .bus(if2), .fsm_state(dbg2));
   ram_responder #(.LAT(0), .WORDS(1024)) dut0 (.CLK(clk), .nRST(nrst), .bus(if0), .fsm_state(dbg0));
   ram_responder #(.LAT(3), .WORDS(1024)) dut3 (.CLK(clk), .nRST(nrst), .bus(if3), .fsm_state(dbg3));

   always #5 clk = ~clk;

   always_comb begin
      case (sel)
         0:       begin obs_state = if0.ramstate; obs_load = if0.ramload; end
         3:       begin obs_state = if3.ramstate; obs_load = if3.ramload; end
         default: begin obs_state = if2.ramstate; obs_load = if2.ramload; end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wait_acc(input string tag);
      for (int i = 0; i < 40 && obs_state != ACCESS; i++) @(negedge clk);
      check(tag, {30'd0, obs_state}, {30'd0, ACCESS});
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
      addr = a; store = d; ren = 1'b0; wen = 1'b1;
      wait_acc(tag);
      @(negedge clk);
      wen = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [31:0] a, input string tag, output logic [31:0] d);
      addr = a; ren = 1'b1; wen = 1'b0;
      wait_acc(tag);
      d = obs_load;
      ren = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_state2", {30'd0, if2.ramstate}, 32'd0);
      check("rst_state0", {30'd0, if0.ramstate}, 32'd0);
      check("rst_load2", if2.ramload, 32'd0);
      check("rst_dbg3", {30'd0, dbg3}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // LAT=2 write then read back
      sel = 2;
      addr = 32'h40; store = 32'hDEADBEEF; wen = 1'b1;
      check("w29_free", {30'd0, obs_state}, {30'd0, FREE});
      @(negedge clk); check("w29_busy1", {30'd0, obs_state}, {30'd0, BUSY});
      @(negedge clk); check("w29_busy2", {30'd0, obs_state}, {30'd0, BUSY});
      @(negedge clk); check("w29_access", {30'd0, obs_state}, {30'd0, ACCESS});
      check("w29_load0", obs_load, 32'd0);
      @(negedge clk); wen = 1'b0;
      @(negedge clk); check("w29_free_end", {30'd0, obs_state}, {30'd0, FREE});
      do_read(32'h40, "r29_acc", rd);
      check("r29_data", rd, 32'hDEADBEEF);

      // LAT=2 restart on address change
      do_write(32'h44, 32'h12345678, "w30_acc");
      addr = 32'h40; ren = 1'b1;
      @(negedge clk); check("r30_busy0", {30'd0, obs_state}, {30'd0, BUSY});
      addr = 32'h44;
      @(negedge clk); check("r30_busy1", {30'd0, obs_state}, {30'd0, BUSY});
      @(negedge clk); check("r30_busy2", {30'd0, obs_state}, {30'd0, BUSY});
      @(negedge clk); check("r30_access", {30'd0, obs_state}, {30'd0, ACCESS});
      check("r30_data", obs_load, 32'h12345678);
      ren = 1'b0;
      @(negedge clk); check("r30_free", {30'd0, obs_state}, {30'd0, FREE});

      // invalid requests: misaligned write, both strobes, out of range
      addr = 32'h41; store = 32'h0BAD0BAD; wen = 1'b1;
      @(negedge clk); check("e31_mis", {30'd0, obs_state}, {30'd0, ERROR});
      @(negedge clk); check("e31_mis_hold", {30'd0, obs_state}, {30'd0, ERROR});
      wen = 1'b0;
      @(negedge clk); check("e31_mis_free", {30'd0, obs_state}, {30'd0, FREE});
      addr = 32'h40; ren = 1'b1; wen = 1'b1;
      @(negedge clk); check("e31_both", {30'd0, obs_state}, {30'd0, ERROR});
      ren = 1'b0; wen = 1'b0;
      @(negedge clk); check("e31_both_free", {30'd0, obs_state}, {30'd0, FREE});
      addr = 32'd4096; ren = 1'b1;
      @(negedge clk); check("e31_range", {30'd0, obs_state}, {30'd0, ERROR});
      ren = 1'b0;
      @(negedge clk); check("e31_range_free", {30'd0, obs_state}, {30'd0, FREE});
      do_read(32'h40, "r31_acc", rd);
      check("r31_unchanged", rd, 32'hDEADBEEF);

      // LAT=2 write abort leaves the word alone
      do_write(32'h50, 32'h00000055, "w34_acc");
      addr = 32'h50; store = 32'h000000AA; wen = 1'b1;
      @(negedge clk); check("a34_busy", {30'd0, obs_state}, {30'd0, BUSY});
      wen = 1'b0;
      @(negedge clk); check("a34_free", {30'd0, obs_state}, {30'd0, FREE});
      do_read(32'h50, "r34_acc", rd);
      check("r34_data", rd, 32'h00000055);

      // LAT=0 back-to-back writes
      sel = 0;
      addr = 32'h0; store = 32'h1; wen = 1'b1;
      @(negedge clk); check("w32_acc0", {30'd0, obs_state}, {30'd0, ACCESS});
      addr = 32'h4;
      @(negedge clk); check("w32_acc1", {30'd0, obs_state}, {30'd0, ACCESS});
      store = 32'h2;
      @(negedge clk); check("w32_acc2", {30'd0, obs_state}, {30'd0, ACCESS});
      wen = 1'b0;
      @(negedge clk); check("w32_free", {30'd0, obs_state}, {30'd0, FREE});
      do_read(32'h0, "r32a_acc", rd);
      check("r32_word0", rd, 32'h1);
      do_read(32'h4, "r32b_acc", rd);
      check("r32_word1", rd, 32'h2);

      // LAT=3 reset in the second busy cycle drops the write
      sel = 3;
      addr = 32'h8; store = 32'hCAFEF00D; wen = 1'b1;
      @(negedge clk); check("w33_busy1", {30'd0, obs_state}, {30'd0, BUSY});
      @(negedge clk); check("w33_busy2", {30'd0, obs_state}, {30'd0, BUSY});
      #1 nrst = 1'b0;
      #1 check("w33_async_free", {30'd0, obs_state}, {30'd0, FREE});
      check("w33_async_load", obs_load, 32'd0);
      wen = 1'b0;
      #1 nrst = 1'b1;
      @(negedge clk);
      do_read(32'h8, "r33_acc", rd);
      check("r33_data", rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter LAT, default 2: number of BUSY cycles before ACCESS; legal range 0..15.
REQ-002 Parameter WORDS, default 1024: memory depth in 32-bit words, power of two.
REQ-003 Port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port nRST  input  1  reset; asynchronous and active-low.
REQ-005 Port ramaddr  input  32  byte address of the request; word-aligned.
REQ-006 Port ramstore  input  32  write data; must be stable while ramWEN is high.
REQ-007 Port ramREN  input  1  read request; held high until ACCESS is seen.
REQ-008 Port ramWEN  input  1  write request; held high until ACCESS is seen.
REQ-009 Port ramload  output  32  read data; valid only in an ACCESS cycle of a read.
REQ-010 Port ramstate  output  2  ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 The block SHALL hold a WORDS x 32 memory array indexed by ramaddr[log2(WORDS)+1:2].
REQ-012 A request SHALL be valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0 and ramaddr < 4*WORDS; any other asserted combination is invalid.
REQ-013 FSM states SHALL be IDLE, WAIT, ACC and ERR, and ramstate SHALL be a registered decode of state: IDLE->FREE, WAIT->BUSY, ACC->ACCESS, ERR->ERROR.
REQ-014 In IDLE, a valid request SHALL latch {ramaddr, op} and load cnt=LAT-1, then go to WAIT; if LAT==0 it SHALL go directly to ACC.
REQ-015 In IDLE, an invalid request SHALL go to ERR, and no request SHALL keep the FSM in IDLE.
REQ-016 In WAIT, dropping both ramREN and ramWEN SHALL return to IDLE with no memory effect (abort).
REQ-017 In WAIT, a change of ramaddr or op versus the latched values SHALL re-latch them, reload cnt=LAT-1 and stay in WAIT (restart); an invalid request SHALL go to ERR.
REQ-018 In WAIT with an unchanged request, cnt==0 SHALL go to ACC; otherwise cnt SHALL decrement.
REQ-019 A request therefore SHALL see exactly LAT BUSY cycles followed by exactly one ACCESS cycle.
REQ-020 In ACC on a read, ramload SHALL equal mem[latched index] combinationally; in every other case ramload SHALL be 0.
REQ-021 In ACC on a write, mem[latched index] SHALL take the live ramstore on the clock edge that leaves ACC.
REQ-022 The ACC exit SHALL go to IDLE if no request is present; a valid request present at that edge, including the same address, SHALL be treated as a new request (latch, go to WAIT or ACC per LAT).
REQ-023 In ERR, the FSM SHALL stay while the invalid request is held, go to IDLE when all requests drop, and treat a valid request as in IDLE.
REQ-024 If ramREN is dropped during ACC, the read SHALL still be counted as complete, and the write in REQ-021 SHALL occur only if ramWEN is high at that edge.
REQ-025 Memory contents SHALL never change except under REQ-021.

Reset
REQ-026 On nRST low, the FSM SHALL go to IDLE, cnt and the latched address/op SHALL clear to 0, ramstate SHALL be FREE and ramload SHALL be 0, all immediately and regardless of CLK.
REQ-027 On nRST low, the whole memory array SHALL clear to 0.
REQ-028 A reset during WAIT or ACC SHALL discard the pending request and SHALL NOT perform any write.

Verification
REQ-029 LAT=2: ramWEN=1, addr 0x40, store 0xDEADBEEF, held until ACCESS, then read addr 0x40 -> FREE, BUSY, BUSY, ACCESS on the write; the read's ACCESS cycle shows ramload=0xDEADBEEF.
REQ-030 LAT=2: ramREN at 0x40, then after one BUSY cycle the address changes to 0x44 -> count restarts, giving 2 further BUSY cycles and then ACCESS with ramload=mem[0x44].
REQ-031 Invalid requests: ramaddr=0x41; then ramREN and ramWEN both high; then ramaddr=4*WORDS -> each gives ramstate=ERROR, memory unchanged, and FREE after the request drops.
REQ-032 LAT=0: back-to-back writes to 0x0 (0x1) and 0x4 (0x2) with no idle gap -> ACCESS in consecutive cycles and both words stored.
REQ-033 LAT=3: ramWEN to 0x8 with nRST pulsed low in the second BUSY cycle -> ramstate becomes FREE asynchronously and a later read of 0x8 returns 0.
REQ-034 LAT=2: a write abort (ramWEN dropped after 1 BUSY cycle) -> IDLE/FREE next cycle and the target word is unchanged.
